// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and sizing helpers for the streaming matrix multiplier.
//   state_t    - FSM state encoding (3 bits)
//   acc_width  - accumulator/result width that cannot overflow for a sum of N products
//   idx_w      - width of a flat row-major element index into an NxN matrix
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int idx_w(input int n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: single registered unsigned DW x DW multiply-accumulate.
//   clk, rst_n  - clock, synchronous active-low reset (clears acc)
//   en          - accumulate this cycle
//   clr         - force acc to zero (idle between compute passes)
//   last        - final term of a dot product: acc restarts at 0, sum carries the result
//   a, b        - operands
//   sum         - acc + a*b, combinational; captured by the caller on the last term
module matmul_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             last,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] sum
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] acc;

  assign prod = a * b;
  assign sum  = acc + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/matmul_stream_seq.sv
// matmul_stream_seq: sequential NxN matrix multiplier C = A x B on one shared MAC.
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - input handshake; in_data carries A then B, row-major
//   out_valid/out_ready  - output handshake; out_data carries C row-major
//   out_last             - marks C[N-1][N-1]
//   busy                 - high whenever the FSM is not idle
//
// state   | meaning
// IDLE    | waiting for A[0][0]
// LOAD_A  | receiving A[0][1] .. A[N-1][N-1]
// LOAD_B  | receiving B[0][0] .. B[N-1][N-1]
// COMPUTE | N^3 MAC cycles, loop order i, j, k (k innermost)
// DRAIN   | presenting C[0][0] .. C[N-1][N-1]
module matmul_stream_seq
  import matmul_pkg::*;
#(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = acc_width(N, DW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int NN = N * N;
  localparam int IW = idx_w(N);
  localparam int CW = $clog2(N);

  state_t state;

  logic [IW-1:0] ld_idx;
  logic [IW-1:0] dr_idx;
  logic [IW-1:0] dr_nxt;
  logic [CW-1:0] ci, cj, ck;
  logic [IW-1:0] a_idx, b_idx, c_idx;

  logic [DW-1:0]    a_mem [NN];
  logic [DW-1:0]    b_mem [NN];
  logic [ACC_W-1:0] c_mem [NN];

  logic             in_hs;
  logic             ld_last, k_last, j_last, i_last;
  logic [ACC_W-1:0] mac_sum;

  assign in_hs   = in_valid & in_ready;
  assign ld_last = (ld_idx == IW'(NN - 1));
  assign k_last  = (ck == CW'(N - 1));
  assign j_last  = (cj == CW'(N - 1));
  assign i_last  = (ci == CW'(N - 1));
  assign dr_nxt  = dr_idx + IW'(1);

  assign a_idx = IW'(int'(ci) * N + int'(ck));
  assign b_idx = IW'(int'(ck) * N + int'(cj));
  assign c_idx = IW'(int'(ci) * N + int'(cj));

  matmul_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == COMPUTE),
    .clr   (state != COMPUTE),
    .last  (k_last),
    .a     (a_mem[a_idx]),
    .b     (b_mem[b_idx]),
    .sum   (mac_sum)
  );

  // Matrix storage is intentionally not reset; ld_idx is 0 in IDLE so A[0][0] lands at 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (in_hs && (state == IDLE || state == LOAD_A)) a_mem[ld_idx] <= in_data;
      if (in_hs && state == LOAD_B)                    b_mem[ld_idx] <= in_data;
      if (state == COMPUTE && k_last)                  c_mem[c_idx]  <= mac_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ld_idx    <= '0;
      dr_idx    <= '0;
      ci        <= '0;
      cj        <= '0;
      ck        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_hs) begin
            ld_idx <= IW'(1);
            state  <= LOAD_A;
            busy   <= 1'b1;
          end
        end
        LOAD_A: begin
          if (in_hs) begin
            if (ld_last) begin
              ld_idx <= '0;
              state  <= LOAD_B;
            end else begin
              ld_idx <= ld_idx + IW'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_hs) begin
            if (ld_last) begin
              ld_idx   <= '0;
              in_ready <= 1'b0;
              ci       <= '0;
              cj       <= '0;
              ck       <= '0;
              state    <= COMPUTE;
            end else begin
              ld_idx <= ld_idx + IW'(1);
            end
          end
        end
        COMPUTE: begin
          if (k_last) begin
            ck <= '0;
            if (j_last) begin
              cj <= '0;
              if (i_last) begin
                // C[0][0] was written long before the final MAC, so it is safe to present now.
                ci        <= '0;
                dr_idx    <= '0;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                out_data  <= c_mem[0];
                state     <= DRAIN;
              end else begin
                ci <= ci + CW'(1);
              end
            end else begin
              cj <= cj + CW'(1);
            end
          end else begin
            ck <= ck + CW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (dr_idx == IW'(NN - 1)) begin
              dr_idx    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              dr_idx   <= dr_nxt;
              out_data <= c_mem[dr_nxt];
              out_last <= (dr_nxt == IW'(NN - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_stream_seq.sv
// Testbench for matmul_stream_seq: an N=3/DW=8 instance driven from a vector table
// plus hand sequences (stalls, abort by reset), and an N=4/DW=4 instance.
module tb_matmul_stream_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0]  in_data;
  logic [17:0] out_data;

  logic        in_valid_4, in_ready_4, out_valid_4, out_ready_4, out_last_4, busy_4;
  logic [3:0]  in_data_4;
  logic [9:0]  out_data_4;

  matmul_stream_seq #(.N(3), .DW(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  matmul_stream_seq #(.N(4), .DW(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_4),
    .in_ready  (in_ready_4),
    .in_data   (in_data_4),
    .out_valid (out_valid_4),
    .out_ready (out_ready_4),
    .out_data  (out_data_4),
    .out_last  (out_last_4),
    .busy      (busy_4)
  );

  typedef struct {
    logic [8:0][7:0]  a;
    logic [8:0][7:0]  b;
    logic [8:0][17:0] c;
  } vec_t;

  vec_t vecs[3];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Streams A then B; returns at the negedge right after the last handshake.
  task automatic load3(input vec_t v, input bit gaps);
    int t;
    for (int e = 0; e < 18; e++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = (e < 9) ? v.a[e] : v.b[e-9];
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("load_in_ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain3(input vec_t v, input bit stall, input string tag);
    int idx;
    int t;
    idx = 0;
    t   = 0;
    while (idx < 9 && t < 400) begin
      if (out_valid) begin
        chk($sformatf("%s_data%0d", tag, idx), 32'(out_data), 32'(v.c[idx]));
        chk($sformatf("%s_last%0d", tag, idx), 32'(out_last), 32'(idx == 8));
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (out_ready) idx++;
      end else begin
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
      end
      t++;
    end
    if (idx < 9) chk($sformatf("%s_drain_timeout", tag), 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    chk($sformatf("%s_valid_after", tag), 32'(out_valid), 32'd0);
    chk($sformatf("%s_busy_after", tag), 32'(busy), 32'd0);
  endtask

  task automatic latency3(input string tag);
    int cnt;
    cnt = 1;
    chk($sformatf("%s_busy_compute", tag), 32'(busy), 32'd1);
    chk($sformatf("%s_in_ready_compute", tag), 32'(in_ready), 32'd0);
    while (!out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk($sformatf("%s_latency", tag), 32'(cnt), 32'd28);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1[9] = '{42, 45, 48, 150, 162, 174, 258, 279, 300};
    int seen;
    int t;
    int idx;

    for (int e = 0; e < 9; e++) begin
      vecs[0].a[e] = 8'(e);
      vecs[0].b[e] = 8'(e + 9);
      vecs[0].c[e] = 18'(c1[e]);
      vecs[1].a[e] = (e == 0 || e == 4 || e == 8) ? 8'd1 : 8'd0;
      vecs[1].b[e] = 8'(e + 1);
      vecs[1].c[e] = 18'(e + 1);
      vecs[2].a[e] = 8'd255;
      vecs[2].b[e] = 8'd255;
      vecs[2].c[e] = 18'd195075;
    end

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    in_valid_4  = 1'b0;
    in_data_4   = '0;
    out_ready_4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst4_out_data", 32'(out_data_4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Table: directed vectors, back-to-back stream, full-rate sink.
    for (int v = 0; v < 3; v++) begin
      load3(vecs[v], 1'b0);
      latency3($sformatf("vec%0d", v));
      drain3(vecs[v], 1'b0, $sformatf("vec%0d", v));
    end

    // Input bubbles and output backpressure.
    load3(vecs[0], 1'b1);
    latency3("stall");
    drain3(vecs[0], 1'b1, "stall");

    // Abort mid-COMPUTE with a one-cycle reset, then rerun.
    load3(vecs[0], 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", 32'(seen), 32'd0);
    load3(vecs[0], 1'b0);
    latency3("rerun");
    drain3(vecs[0], 1'b0, "rerun");

    // N=4, DW=4: all 15s.
    for (int e = 0; e < 32; e++) begin
      in_valid_4 = 1'b1;
      in_data_4  = 4'hF;
      t = 0;
      while (!in_ready_4 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("n4_in_ready_timeout", 32'(in_ready_4), 32'd1);
      @(negedge clk);
    end
    in_valid_4  = 1'b0;
    out_ready_4 = 1'b1;
    idx = 0;
    t   = 0;
    while (idx < 16 && t < 400) begin
      if (out_valid_4) begin
        chk($sformatf("n4_data%0d", idx), 32'(out_data_4), 32'd900);
        chk($sformatf("n4_last%0d", idx), 32'(out_last_4), 32'(idx == 15));
        idx++;
      end
      @(negedge clk);
      t++;
    end
    if (idx < 16) chk("n4_drain_timeout", 32'(out_valid_4), 32'd1);
    chk("n4_valid_after", 32'(out_valid_4), 32'd0);
    chk("n4_busy_after", 32'(busy_4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
